blink_arbiter: RTL and testbench
================================

BLINK_ARBITER -- requirements
Module: blink_arbiter

Interface
REQ-001 The module SHALL have parameter CBITS, default 21, giving the half-period counter width; each LED half-period SHALL be 2^CBITS clk cycles.
REQ-002 The module SHALL have parameter NREQ, fixed at 4, giving the number of requesters; it is not overridable.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port req, input, 4 bits: per-requester blink request, level.
REQ-006 The module SHALL have port blinks, input, 16 bits: per-requester blink count, 4 bits each; requester i uses bits [4i+3:4i].
REQ-007 The module SHALL have port gnt, output, 4 bits: one-hot, one-cycle grant pulse.
REQ-008 The module SHALL have port owner, output, 2 bits: index of the requester currently served.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a job is in progress.
REQ-010 The module SHALL have port led, output, 1 bit: shared LED drive.
REQ-011 The module SHALL have port flg, output, 1 bit: one-cycle pulse at each half-period boundary while busy.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.

Function
REQ-013 The module SHALL implement an FSM with states IDLE, ON, OFF and GAP; all outputs SHALL be registered.
REQ-014 The module SHALL hold a CBITS-bit phase counter, cleared on every state entry, incrementing each cycle in ON, OFF and GAP; tick SHALL be defined as phase counter equal to all-ones.
REQ-015 In IDLE with any req bit high, the module SHALL select a requester by round-robin, starting the search at (last_owner+1) mod 4 and wrapping.
REQ-016 On selection, at the next edge the module SHALL: pulse gnt[i] for exactly 1 cycle, set owner=i, latch remaining=blinks[i], and set busy=1.
REQ-017 On selection with a latched count above 0, the module SHALL enter ON with led=1 in the same cycle as gnt.
REQ-018 On selection with a latched count of 0, the module SHALL enter GAP directly with led=0 and produce no blink.
REQ-019 On a tick in ON, the module SHALL set led=0 and enter OFF.
REQ-020 On a tick in OFF with remaining>1, the module SHALL decrement remaining, set led=1 and enter ON.
REQ-021 On a tick in OFF with remaining==1, the module SHALL enter GAP with led=0.
REQ-022 On a tick in GAP, the module SHALL enter IDLE with busy=0, pulse done for 1 cycle, and record last_owner=owner.
REQ-023 flg SHALL pulse on the cycle after each tick taken in ON, OFF or GAP, and SHALL never pulse in IDLE.
REQ-024 Arbitration SHALL occur only in IDLE; req changes while busy SHALL be ignored.
REQ-025 The earliest next grant SHALL be the cycle after done, i.e. no back-to-back overlap.
REQ-026 blinks SHALL be sampled only at selection; later changes SHALL NOT affect the running job.
REQ-027 A requester SHALL deassert req[i] on or before the cycle gnt[i] is high; a req still high when IDLE is next re-entered SHALL be treated as a new request.
REQ-028 A req pulse that drops before selection SHALL be lost without error.
REQ-029 owner SHALL hold its value after done until the next grant.
REQ-030 Simultaneous requests SHALL be served strictly in round-robin order, so no requester waits more than 3 jobs.

Reset
REQ-031 While rst is low, the module SHALL asynchronously force: state=IDLE, led=0, busy=0, flg=0, done=0, gnt=0, owner=0, phase counter=0, remaining=0, last_owner=3 (so requester 0 has first priority).
REQ-032 A reset asserted mid-job SHALL abort the job with no done pulse; arbitration SHALL resume on the first edge after rst rises.

Verification (CBITS=2, half-period = 4 cycles)
REQ-033 Scenario: req=0001, blinks[3:0]=2 -> gnt=0001 for 1 cycle, with led high that same cycle; led pattern 4 high, 4 low, 4 high, 4 low, then 4 low (GAP); done pulses 20 cycles after gnt; flg pulses 5 times.
REQ-034 Scenario: req=1111 held, all counts 1 -> grants in order 0,1,2,3,0; each grant 1 cycle after the previous done; owner follows.
REQ-035 Scenario: blinks[7:4]=0, req=0010 -> gnt[1], led stays 0, done 4 cycles later.
REQ-036 Scenario: rst low in the 2nd ON phase of a 3-blink job -> led=0, busy=0 immediately with no clock edge, and no done; after release, a pending req=0100 is granted to requester 2 first.
REQ-037 Scenario: blinks changed and req toggled during a job -> blink count unchanged and no extra gnt; blinks=15 gives 15 led pulses.

Source files
------------

// File: rtl/blink_arbiter.sv
// blink_arbiter: round-robin arbiter for four requesters sharing one LED.
// The selected requester's blink count is latched at grant time; the LED then
// blinks that many times (each half-period 2^CBITS cycles), followed by one
// dark GAP half-period before the arbiter returns to IDLE.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - asynchronous active-low reset
//   req    - per-requester blink request (level)
//   blinks - per-requester blink count, requester i uses [4i+3:4i]
//   gnt    - one-hot, one-cycle grant pulse
//   owner  - index of the requester currently (or last) served
//   busy   - high while a job is in progress
//   led    - shared LED drive
//   flg    - one-cycle pulse after each half-period boundary of a job
//   done   - one-cycle pulse when a job completes
module blink_arbiter #(
    parameter int unsigned CBITS = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] blinks,
    output logic [3:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        led,
    output logic        flg,
    output logic        done
);

    localparam int unsigned NREQ = 4;

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t           state;
    logic [CBITS-1:0] phase;
    logic [3:0]       remaining;
    logic [1:0]       last_owner;

    logic             tick;
    logic             found;
    logic [1:0]       pick;
    logic [1:0]       cand;
    logic [3:0]       pick_cnt;

    assign tick = &phase;

    // Round-robin search starting at last_owner+1. Walking from the farthest
    // candidate back to the nearest lets the nearest requester win.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = last_owner + 2'(k);
            if (req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        pick_cnt = '0;
        unique case (pick)
            2'd0: pick_cnt = blinks[3:0];
            2'd1: pick_cnt = blinks[7:4];
            2'd2: pick_cnt = blinks[11:8];
            2'd3: pick_cnt = blinks[15:12];
            default: pick_cnt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            remaining  <= '0;
            last_owner <= 2'd3;
            gnt        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            led        <= 1'b0;
            flg        <= 1'b0;
            done       <= 1'b0;
        end else begin
            gnt  <= '0;
            flg  <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    phase <= '0;
                    if (found) begin
                        gnt       <= 4'b0001 << pick;
                        owner     <= pick;
                        remaining <= pick_cnt;
                        busy      <= 1'b1;
                        if (pick_cnt != '0) begin
                            led   <= 1'b1;
                            state <= ON;
                        end else begin
                            led   <= 1'b0;
                            state <= GAP;
                        end
                    end
                end
                ON: begin
                    if (tick) begin
                        phase <= '0;
                        flg   <= 1'b1;
                        led   <= 1'b0;
                        state <= OFF;
                    end else begin
                        phase <= phase + CBITS'(1);
                    end
                end
                OFF: begin
                    if (tick) begin
                        phase <= '0;
                        flg   <= 1'b1;
                        if (remaining > 4'd1) begin
                            remaining <= remaining - 4'd1;
                            led       <= 1'b1;
                            state     <= ON;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        phase <= phase + CBITS'(1);
                    end
                end
                GAP: begin
                    if (tick) begin
                        phase      <= '0;
                        flg        <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        last_owner <= owner;
                        state      <= IDLE;
                    end else begin
                        phase <= phase + CBITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_arbiter.sv
module tb_blink_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] blinks;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        led;
    logic        flg;
    logic        done;

    blink_arbiter #(.CBITS(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .blinks (blinks),
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .led    (led),
        .flg    (flg),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] owner;
        int         n;
        int         gap;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] blinks;
        logic [1:0]  owner;
        int          n;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    int errors = 0;
    int checks = 0;
    int gnt_seen = 0;
    int jobs_done = 0;
    int g_exp = 0;
    int d_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_gnt(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (gnt_seen >= target) return;
        end
        chk("gnt_timeout", gnt_seen, target);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (jobs_done >= target) return;
        end
        chk("done_timeout", jobs_done, target);
    endtask

    // Monitor: pops the expected job at each grant and checks the LED
    // waveform, flg count and duration against the blink count.
    int   cyc = 0;
    int   last_done = 0;
    bit   active = 0;
    int   t = 0;
    int   n = 0;
    int   dur = 0;
    int   led_err = 0;
    int   flg_cnt = 0;
    bit   exp_led;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            active = 0;
        end else begin
            if (gnt != 4'b0000) begin
                gnt_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", gnt, 0);
                end else begin
                    e = sb.pop_front();
                    chk("gnt_onehot", gnt, 4'b0001 << e.owner);
                    chk("owner", owner, e.owner);
                    chk("busy_at_gnt", busy, 1);
                    if (e.gap >= 0) chk("gnt_gap", cyc - last_done, e.gap);
                    active  = 1;
                    t       = 0;
                    n       = e.n;
                    dur     = (n == 0) ? 4 : 8 * n + 4;
                    led_err = 0;
                    flg_cnt = 0;
                end
            end
            if (active) begin
                exp_led = (t < 8 * n) && (((t / 4) % 2) == 0);
                if (led !== exp_led || (t < dur && busy !== 1'b1)) led_err++;
                if (flg) flg_cnt++;
                if (done) begin
                    chk("duration", t, dur);
                    chk("flg_count", flg_cnt, (n == 0) ? 1 : 2 * n + 1);
                    chk("led_pattern_errs", led_err, 0);
                    chk("busy_at_done", busy, 0);
                    active    = 0;
                    last_done = cyc;
                    jobs_done++;
                end else if (t >= dur + 8) begin
                    chk("missing_done", t, dur);
                    active = 0;
                end
                t++;
            end else if (done || flg) begin
                chk("stray_done_flg", {done, flg}, 0);
            end
        end
    end

    initial begin
        vecs[0] = '{4'b0001, 16'h0002, 2'd0, 2};
        vecs[1] = '{4'b0010, 16'h0005, 2'd1, 0};
        vecs[2] = '{4'b1001, 16'h1003, 2'd3, 1};
        vecs[3] = '{4'b1001, 16'h1003, 2'd0, 3};
        vecs[4] = '{4'b0110, 16'h0210, 2'd1, 1};
        vecs[5] = '{4'b0110, 16'h0210, 2'd2, 2};

        rst    = 1'b0;
        req    = '0;
        blinks = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_led", led, 0);
        chk("rst_flg", flg, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Single jobs, round-robin order carried across vectors
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            req    = vecs[i].req;
            blinks = vecs[i].blinks;
            sb.push_back('{vecs[i].owner, vecs[i].n, -1});
            g_exp++;
            wait_gnt(g_exp, 20);
            #1 req = '0;
            d_exp++;
            wait_done(d_exp, 200);
            repeat (2) @(posedge clk);
        end

        // All requesting with counts of 1: strict rotation, back-to-back grants
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        blinks = 16'h1111;
        sb.push_back('{2'd0, 1, -1});
        sb.push_back('{2'd1, 1, 1});
        sb.push_back('{2'd2, 1, 1});
        sb.push_back('{2'd3, 1, 1});
        sb.push_back('{2'd0, 1, 1});
        req = 4'b1111;
        g_exp += 5;
        wait_gnt(g_exp, 100);
        #1 req = '0;
        d_exp += 5;
        wait_done(d_exp, 100);
        repeat (2) @(posedge clk);

        // Inputs disturbed mid-job: latched count of 15 must run to completion
        @(posedge clk);
        #1;
        blinks = 16'h00F0;
        req    = 4'b0010;
        sb.push_back('{2'd1, 15, -1});
        g_exp++;
        wait_gnt(g_exp, 20);
        #1 req = '0;
        repeat (10) @(posedge clk);
        #1;
        blinks = 16'h0000;
        req    = 4'b0011;
        repeat (5) @(posedge clk);
        #1 req = 4'b0001;
        repeat (5) @(posedge clk);
        #1 req = '0;
        d_exp++;
        wait_done(d_exp, 300);
        repeat (10) @(posedge clk);
        chk("extra_gnt", gnt_seen, g_exp);

        // Reset during the second ON phase of a 3-blink job
        @(posedge clk);
        #1;
        blinks = 16'h0103;
        req    = 4'b0001;
        sb.push_back('{2'd0, 3, -1});
        g_exp++;
        wait_gnt(g_exp, 20);
        #1 req = 4'b0100;
        repeat (8) @(posedge clk);
        #2;
        chk("led_before_abort", led, 1);
        rst = 1'b0;
        #1;
        chk("abort_led", led, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_owner", owner, 0);
        chk("abort_done", done, 0);
        sb.push_back('{2'd2, 1, -1});
        g_exp++;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        wait_gnt(g_exp, 2);
        #1 req = '0;
        d_exp++;
        wait_done(d_exp, 100);
        chk("jobs_after_abort", jobs_done, d_exp);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
